// File: rtl/mem_fifo_pkg.sv
// ============================================================================
// mem_fifo_pkg : shared defaults, address-width helper and memory op encoding
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_fifo_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;

  // One-hot memory operation encoding: bit0 = write, bit1 = read
  localparam logic [1:0] C_OP_IDLE = 2'b00;
  localparam logic [1:0] C_OP_WR   = 2'b01;
  localparam logic [1:0] C_OP_RD   = 2'b10;

  function automatic int aw_of(input int depth);
    int a;
    a = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) a = i + 1;
    end
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_fifo_ptr.sv
// ============================================================================
// mem_fifo_ptr : AW-bit wrap-around pointer with increment enable
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_fifo_ptr #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] r_ptr;

  // Depth is a power of two, so natural overflow gives the DEPTH-1 -> 0 wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_ptr <= '0;
    else if (inc) r_ptr <= r_ptr + AW'(1);
  end

  assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/mem_fifo_ctrl.sv
// ============================================================================
// mem_fifo_ctrl : valid/ready FIFO controller in front of a 1-port sync memory
// Optional MEM_FIFO_BYPASS_EN: empty-FIFO pushes go straight to the output reg
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_fifo_ctrl
  import mem_fifo_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = aw_of(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [AW:0]      count
);

  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [AW:0]      r_mcount;
  logic             r_rd_pend;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [AW-1:0]    w_wptr;
  logic [AW-1:0]    w_rptr;
  logic             w_rd_go;
  logic             w_push;
  logic             w_bypass;
  logic [1:0]       w_mem_op;

  assign count = r_mcount + {{AW{1'b0}}, r_rd_pend} + {{AW{1'b0}}, r_out_valid};

  assign w_rd_go  = (r_mcount != '0) && !r_rd_pend && (!r_out_valid || out_ready);
  assign in_ready = (r_mcount != C_FULL) && !w_rd_go;
  assign w_push   = in_valid && in_ready;

`ifdef MEM_FIFO_BYPASS_EN
  // Output register is free (or being freed) and nothing older is queued
  assign w_bypass = w_push && (r_mcount == '0) && !r_rd_pend && (!r_out_valid || out_ready);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_mem_op  = w_rd_go             ? C_OP_RD :
                     (w_push && !w_bypass) ? C_OP_WR : C_OP_IDLE;
  assign mem_wr    = (w_mem_op == C_OP_WR);
  assign mem_rd    = (w_mem_op == C_OP_RD);
  assign mem_addr  = w_rd_go ? w_rptr : w_wptr;
  assign mem_wdata = in_data;

  mem_fifo_ptr #(.AW(AW)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mem_wr),
    .ptr   (w_wptr)
  );

  mem_fifo_ptr #(.AW(AW)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mem_rd),
    .ptr   (w_rptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcount  <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= mem_rd;
      if (mem_wr)      r_mcount <= r_mcount + (AW+1)'(1);
      else if (mem_rd) r_mcount <= r_mcount - (AW+1)'(1);
    end
  end

  // A capture takes precedence over a pop so the head never goes invalid mid-stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (r_rd_pend) begin
      r_out_valid <= 1'b1;
      r_out_data  <= mem_rdata;
    end else if (w_bypass) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

`default_nettype wire
